sram_init_rw_ctrl: RTL and testbench

SRAM_INIT_RW_CTRL -- requirements
Module: sram_init_rw_ctrl

---
 rtl/sram_init_rw_ctrl_pkg.sv | 16 +
 rtl/sram_resp_fifo.sv | 63 ++++++
 rtl/sram_init_rw_ctrl.sv | 123 ++++++++++++
 tb/tb_sram_init_rw_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_init_rw_ctrl_pkg.sv
// Shared definitions for the SRAM init/read-write controller.
//   ADDR_W_DEF / DATA_W_DEF / DEPTH_DEF / RESP_DEPTH_DEF : parameter defaults
//   state_e : controller FSM states (INIT zeroes the memory, RUN serves requests)
package sram_init_rw_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 9;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned DEPTH_DEF      = 512;
  localparam int unsigned RESP_DEPTH_DEF = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small response FIFO holding SRAM read data until the consumer takes it.
//   clock, reset     : clock and synchronous active-high reset (empties the FIFO)
//   push, push_data  : write one entry
//   pop              : remove the head entry (ignored when empty)
//   valid, data      : head entry is present / head entry value
module sram_resp_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  // A full FIFO can still accept a push in the cycle its head is popped.
  assign do_push = push && ((count != CNT_W'(RESP_DEPTH)) || do_pop);

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_init_rw_ctrl.sv
// Single-port SRAM controller: zeroes every entry after reset, then serves
// masked writes and credit-limited reads with in-order read responses.
//   clock, reset          : sole clock (also the SRAM clock), sync active-high reset
//   req_*                 : request channel (valid/ready, write, addr, mask, wdata)
//   resp_*                : read-response channel (valid/ready, data)
//   init_done             : zeroing pass complete
//   RW0_*                 : SRAM port; RW0_rdata valid one cycle after a read enable
module sram_init_rw_ctrl
  import sram_init_rw_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int unsigned CRED_W = $clog2(RESP_DEPTH + 1);

  state_e            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [CRED_W-1:0] credit;
  logic              rd_pend;
  logic              accept;
  logic              rd_accept;
  logic              pop;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;

  // Handshake outputs are derived from registered state and masked while
  // reset is high, so a reset cycle never shows a stale RUN-state value.
  assign req_ready  = !reset && (state == RUN) && (credit != '0);
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_write;
  assign resp_valid = !reset && fifo_valid;
  assign resp_data  = resp_valid ? fifo_data : '0;
  assign pop        = resp_valid && resp_ready;
  assign init_done  = !reset && (state == RUN);

  // FSM: walk every address once in INIT, then stay in RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      if (init_cnt == ADDR_W'(DEPTH - 1)) begin
        state <= RUN;
      end
      init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  // Credit bounds outstanding reads (pending + queued) to the FIFO depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit  <= CRED_W'(RESP_DEPTH);
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      case ({rd_accept, pop})
        2'b10:   credit <= credit - CRED_W'(1);
        2'b01:   credit <= credit + CRED_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  // SRAM port mux: zeroing writes in INIT, accepted requests in RUN, else idle.
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (!reset) begin
      if (state == INIT) begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = init_cnt;
        RW0_wmask = '1;
      end else if (accept) begin
        RW0_en    = 1'b1;
        RW0_wmode = req_write;
        RW0_addr  = req_addr;
        RW0_wmask = req_mask;
        RW0_wdata = req_wdata;
      end
    end
  end

  // Read data arrives the cycle after the read and is queued for the consumer.
  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (RW0_rdata),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (fifo_data)
  );

endmodule

// File: tb/tb_sram_init_rw_ctrl.sv
// Directed bench for sram_init_rw_ctrl with a behavioural masked SRAM.
module tb_sram_init_rw_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_mask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sram_init_rw_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wmask  (RW0_wmask),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  // Memory model, preloaded with a non-zero pattern so zeroing is visible.
  logic [DW-1:0] mem [DEPTH] = '{default: 8'h5A};
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= (mem[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
      else           RW0_rdata     <= mem[RW0_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sram(input string tag, input logic en, input logic wm,
                          input logic [8:0] a, input logic [7:0] m, input logic [7:0] d);
    chk(tag, 32'({RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}), 32'({en, wm, a, m, d}));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [8:0] a,
                       input logic [7:0] m, input logic [7:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_mask  = m;
    req_wdata = d;
    #1;
  endtask

  // Present a request and check it is accepted onto the SRAM port this cycle.
  task automatic req_cyc(input string tag, input logic w, input logic [8:0] a,
                         input logic [7:0] m, input logic [7:0] d);
    drive(1'b1, w, a, m, d);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk_sram({tag, "_port"}, 1'b1, w, a, m, d);
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(resp_valid), 32'(v));
    if (v) chk({tag, "_data"}, 32'(resp_data), 32'(d));
  endtask

  // One zeroing pass: DEPTH cycles of full-mask zero writes in address order.
  task automatic init_pass(input string tag);
    for (int c = 0; c < int'(DEPTH); c++) begin
      #1;
      chk_sram({tag, "_port"}, 1'b1, 1'b1, 9'(c), 8'hFF, 8'h00);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_done"}, 32'(init_done), 32'd0);
      chk({tag, "_resp"}, 32'(resp_valid), 32'd0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0;
    step(); step();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk_resp("rst_resp", 1'b0, 8'h00);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk_sram("rst_port", 1'b0, 1'b0, 9'd0, 8'h00, 8'h00);

    // Zeroing pass with a read request held pending throughout.
    reset = 1'b0;
    init_pass("init1");
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk("run_done", 32'(init_done), 32'd1);
    chk("run_ready", 32'(req_ready), 32'd1);
    chk_sram("run_idle", 1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    step();

    // Write then read the same address on the next cycle.
    resp_ready = 1'b1;
    req_cyc("wr5", 1'b1, 9'd5, 8'hFF, 8'hA5); chk_resp("wr5_r", 1'b0, 8'h00); step();
    req_cyc("rd5", 1'b0, 9'd5, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk_resp("rd5_t1", 1'b0, 8'h00);
    chk_sram("idle_t1", 1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    step();
    chk_resp("rd5_t2", 1'b1, 8'hA5); step();
    chk_resp("rd5_t3", 1'b0, 8'h00);

    // Masked write, then read it back and read an untouched (zeroed) address.
    req_cyc("wr7", 1'b1, 9'd7, 8'h0F, 8'hFF); step();
    req_cyc("rd7", 1'b0, 9'd7, 8'h00, 8'h00); step();
    req_cyc("rd300", 1'b0, 9'd300, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk_resp("rd7_r", 1'b1, 8'h0F); step();
    chk_resp("rd300_r", 1'b1, 8'h00); step();
    chk_resp("rd_empty", 1'b0, 8'h00);

    // Credit exhaustion with the consumer stalled.
    req_cyc("wr10", 1'b1, 9'd10, 8'hFF, 8'h11); step();
    req_cyc("wr11", 1'b1, 9'd11, 8'hFF, 8'h22); step();
    req_cyc("wr12", 1'b1, 9'd12, 8'hFF, 8'h33); step();
    req_cyc("wr13", 1'b1, 9'd13, 8'hFF, 8'h44); step();
    resp_ready = 1'b0;
    req_cyc("cr_rd10", 1'b0, 9'd10, 8'h00, 8'h00); step();
    req_cyc("cr_rd11", 1'b0, 9'd11, 8'h00, 8'h00); step();
    req_cyc("cr_rd12", 1'b0, 9'd12, 8'h00, 8'h00);
    chk_resp("cr_d2", 1'b1, 8'h11); step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 9'd13, 8'h00, 8'h00);
      chk("cr_block_ready", 32'(req_ready), 32'd0);
      chk_sram("cr_block_port", 1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
      chk_resp("cr_hold", 1'b1, 8'h11);
      step();
    end
    resp_ready = 1'b1;
    drive(1'b1, 1'b0, 9'd13, 8'h00, 8'h00);
    chk("cr_d5_ready", 32'(req_ready), 32'd0);
    chk_resp("cr_d5", 1'b1, 8'h11); step();
    req_cyc("cr_rd13", 1'b0, 9'd13, 8'h00, 8'h00);
    chk_resp("cr_d6", 1'b1, 8'h22); step();
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk_resp("cr_d7", 1'b1, 8'h33); step();
    chk_resp("cr_d8", 1'b1, 8'h44); step();
    chk_resp("cr_d9", 1'b0, 8'h00);

    // Streaming: one read per cycle with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      req_cyc("st_wr", 1'b1, 9'(i), 8'hFF, pat(i));
      step();
    end
    for (int i = 0; i < 103; i++) begin
      if (i < 100) req_cyc("st_rd", 1'b0, 9'(i), 8'h00, 8'h00);
      else         drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
      if (i >= 2 && i < 102) chk_resp("st_resp", 1'b1, pat(i - 2));
      else                   chk_resp("st_gap", 1'b0, 8'h00);
      step();
    end

    // Reset with two reads outstanding, then a full second zeroing pass.
    resp_ready = 1'b0;
    req_cyc("pre_rd1", 1'b0, 9'd1, 8'h00, 8'h00); step();
    req_cyc("pre_rd2", 1'b0, 9'd2, 8'h00, 8'h00); step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk_resp("mid_rst_resp", 1'b0, 8'h00);
    chk("mid_rst_data", 32'(resp_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk_sram("mid_rst_port", 1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    step();
    reset = 1'b0;
    init_pass("init2");
    drive(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
    chk("run2_done", 32'(init_done), 32'd1);
    chk_resp("run2_resp", 1'b0, 8'h00);
    // Credit restored to three; address 1 must read back as re-zeroed.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 9'd1, 8'h00, 8'h00);
      chk("run2_credit", 32'(req_ready), 32'(k < 3));
      if (k >= 2) chk_resp("run2_zero", 1'b1, 8'h00);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
